microprocessor: RTL and testbench
=================================

// Module: microprocessor
// PURPOSE
//   Single-cycle RV32I integer core with internal instruction and data memories.
//   Retires one instruction per clk edge in execute mode.
//   Load mode streams program words in through the instruction port.
//   Top of the CPU hierarchy; a bench drives it directly.
// PARAMETERS
//   IMEM_DEPTH  256  instruction memory size in 32-bit words (power of 2)
//   DMEM_DEPTH  256  data memory size in 32-bit words (power of 2)
//   RESET_PC    0    PC value after reset (byte address)
// PORTS
//   clk          in   1   single clock; all state updates on rising edge
//   rst          in   1   synchronous, active-high reset
//   instruction  in   32  program word to store when enable=1
//   enable       in   1   1 = program-load mode, 0 = execute mode
//   res_out      out  32  registered value of the last register-file write
// BEHAVIOUR
//   Reset (rst=1 at edge, priority over enable):
//     - pc<=RESET_PC, load_ptr<=0, x1..x31<=0, res_out<=0
//     - imem/dmem contents unchanged
//   Load mode (enable=1):
//     - imem[load_ptr]<=instruction; load_ptr<=load_ptr+1, wraps mod IMEM_DEPTH
//     - pc, regfile, dmem, res_out hold
//   Execute mode (enable=0), per edge:
//     - Fetch imem[pc[log2(IMEM_DEPTH)+1:2]] combinationally, then decode and execute.
//     - Write back rd; update pc (default pc+4).
//     - Latency: 1 cycle per instruction; no stalls; no pipeline.
//   Supported instructions:
//     - LUI, AUIPC, JAL, JALR (target & ~1)
//     - BEQ/BNE/BLT/BGE/BLTU/BGEU
//     - LW, SW
//     - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI
//     - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA
//   Unsupported or illegal opcode, and LB/LH/SB/SH etc.: NOP (pc+4, no writes).
//   Immediates: sign-extended per I/S/B/U/J format. All arithmetic is mod 2^32.
//   Shift amount = rs2[4:0] or imm[4:0]; SRA/SRAI are arithmetic.
//   SLT is signed compare; SLTU is unsigned compare.
//   x0 reads 0 always; writes to x0 discarded; res_out not updated for rd=0.
//   Regfile: 2 combinational read ports, 1 write port at the edge.
//     A same-cycle read sees the old value.
//   Data memory:
//     - address = ALU result[log2(DMEM_DEPTH)+1:2]; low 2 bits ignored
//     - address wraps mod DMEM_DEPTH
//     - LW reads combinationally; SW writes at the edge
//   PC wraps modulo IMEM_DEPTH*4. Branch/jump offsets are relative to the current pc.
//   res_out <= writeback data whenever rd!=0 is written; otherwise holds.
//   Simultaneous rst and enable: reset wins.
//   Leaving load mode: execution resumes from the current pc, not from 0.
// STRUCTURE
//   Package rv32i_pkg holds:
//     - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
//     - funct3 codes
//     - alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND)
//   Sub-module rv32i_alu: combinational (a, b, alu_op) -> result.
//     Branch compares are also done here.
//   Decode, immediate generation, regfile, memories and pc logic stay in microprocessor.
// TESTING
//   - Reset: rst=1 for 1 edge -> pc=0, res_out=0, x1..x31=0.
//   - Load then run: load ADDI x1,x0,5 / ADDI x2,x0,7 / ADD x3,x1,x2 (enable=1), rst, enable=0, 3 edges
//       -> x3=12, res_out=12.
//   - Memory: ADDI x1,x0,-1; SW x1,8(x0); LW x4,8(x0)
//       -> dmem[2]=0xFFFFFFFF, x4=0xFFFFFFFF.
//   - Branch/jump: BEQ x0,x0,+8 skips the next word; JAL x5,+8 at pc=16
//       -> x5=20, pc=24.
//   - Edges: ADDI x0,x0,9 -> x0 stays 0 and res_out unchanged;
//       SRAI of 0x80000000 by 4 -> 0xF8000000;
//       SLTU of 1 vs -1 -> 1.
//   - Load mode mid-program: assert enable=1 for 2 edges -> pc frozen, no regfile writes;
//       load_ptr advances by 2.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 codes and the ALU operation set.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_JALR    = 3'b000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // alt selects SUB/SRA (instruction bit 30) where the encoding allows it
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_from_f3 = ALU_ADD;
        case (f3)
            F3_ADD_SUB: alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     alu_from_f3 = ALU_SLL;
            F3_SLT:     alu_from_f3 = ALU_SLT;
            F3_SLTU:    alu_from_f3 = ALU_SLTU;
            F3_XOR:     alu_from_f3 = ALU_XOR;
            F3_SR:      alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      alu_from_f3 = ALU_OR;
            F3_AND:     alu_from_f3 = ALU_AND;
            default:    alu_from_f3 = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I ALU; also supplies the equality and ordering flags used by branches.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_t     alu_op_i,
    output logic [31:0] result_o,
    output logic        eq_o,
    output logic        lt_o,
    output logic        ltu_o
);

    logic lt, ltu;

    always_comb begin
        lt       = $signed(a_i) < $signed(b_i);
        ltu      = a_i < b_i;
        eq_o     = (a_i == b_i);
        lt_o     = lt;
        ltu_o    = ltu;
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SLT:  result_o = {31'b0, lt};
            ALU_SLTU: result_o = {31'b0, ltu};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/microprocessor.sv
// Single-cycle RV32I core with internal instruction/data memories and a program-load port.
module microprocessor
    import rv32i_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        enable,
    output logic [31:0] res_out
);

    localparam int unsigned IAW     = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW     = $clog2(DMEM_DEPTH);
    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

    logic [31:0]    pc_q, pc_d;
    logic [IAW-1:0] load_ptr_q;
    logic [31:0]    res_out_q;
    logic [31:0]    rf_q   [32];
    logic [31:0]    imem_q [IMEM_DEPTH];
    logic [31:0]    dmem_q [DMEM_DEPTH];

    logic [31:0] instr, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, pc_plus4, wb_data, dmem_rdata;
    logic [31:0] alu_b, alu_res;
    alu_op_t     alu_op;
    logic        alu_eq, alu_lt, alu_ltu;
    logic        rf_we, dmem_we, taken;

    assign instr    = imem_q[pc_q[IAW+1:2]];
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign rs1_val  = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : rf_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;
    assign dmem_rdata = dmem_q[alu_res[DAW+1:2]];
    assign res_out  = res_out_q;

    rv32i_alu u_alu (
        .a_i      (rs1_val),
        .b_i      (alu_b),
        .alu_op_i (alu_op),
        .result_o (alu_res),
        .eq_o     (alu_eq),
        .lt_o     (alu_lt),
        .ltu_o    (alu_ltu)
    );

    always_comb begin
        alu_b   = imm_i;
        alu_op  = ALU_ADD;
        rf_we   = 1'b0;
        dmem_we = 1'b0;
        wb_data = alu_res;
        taken   = 1'b0;
        pc_d    = pc_plus4;
        case (opcode)
            OPC_OP: begin
                alu_b  = rs2_val;
                alu_op = alu_from_f3(f3, instr[30]);
                rf_we  = 1'b1;
            end
            OPC_OP_IMM: begin
                // bit 30 is part of the immediate except for the shift-right pair
                alu_op = alu_from_f3(f3, (f3 == F3_SR) && instr[30]);
                rf_we  = 1'b1;
            end
            OPC_LOAD: begin
                rf_we   = (f3 == F3_LW);
                wb_data = dmem_rdata;
            end
            OPC_STORE: begin
                alu_b   = imm_s;
                dmem_we = (f3 == F3_SW);
            end
            OPC_BRANCH: begin
                alu_b = rs2_val;
                case (f3)
                    F3_BEQ:  taken = alu_eq;
                    F3_BNE:  taken = !alu_eq;
                    F3_BLT:  taken = alu_lt;
                    F3_BGE:  taken = !alu_lt;
                    F3_BLTU: taken = alu_ltu;
                    F3_BGEU: taken = !alu_ltu;
                    default: taken = 1'b0;
                endcase
                if (taken) pc_d = pc_q + imm_b;
            end
            OPC_JAL: begin
                rf_we   = 1'b1;
                wb_data = pc_plus4;
                pc_d    = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (f3 == F3_JALR) begin
                    rf_we   = 1'b1;
                    wb_data = pc_plus4;
                    pc_d    = alu_res & ~32'd1;
                end
            end
            OPC_LUI: begin
                rf_we   = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                rf_we   = 1'b1;
                wb_data = pc_q + imm_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            load_ptr_q <= '0;
            res_out_q  <= '0;
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (enable) begin
            load_ptr_q <= load_ptr_q + IAW'(1);
        end else begin
            pc_q <= pc_d & PC_MASK;
            if (rf_we && (rd != 5'd0)) begin
                rf_q[rd]  <= wb_data;
                res_out_q <= wb_data;
            end
        end
    end

    // Memories are deliberately outside the reset domain so programs survive rst
    always_ff @(posedge clk) begin
        if (!rst && enable) imem_q[load_ptr_q] <= instruction;
    end

    always_ff @(posedge clk) begin
        if (!rst && !enable && dmem_we) dmem_q[alu_res[DAW+1:2]] <= rs2_val;
    end

endmodule

// File: tb/tb_microprocessor.sv
// Scoreboarded bench for microprocessor: ISA-level reference model, directed programs and random programs.
module tb_microprocessor;

    localparam int IMEM = 256;
    localparam int DMEM = 256;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] instruction;
    logic [31:0] res_out;

    microprocessor #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM), .RESET_PC(32'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .enable      (enable),
        .res_out     (res_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [95:0]   name;
        int            edge_no;
        logic [31:0]   pc;
        logic [31:0]   res;
        logic [7:0]    ptr;
        logic [1023:0] rf;
        logic          st_en;
        int            st_idx;
        logic [31:0]   st_val;
        logic          xr_en;
        int            xr_idx;
        logic [31:0]   xr_val;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Architectural reference state
    logic [31:0] m_rf   [32];
    logic [31:0] m_imem [IMEM];
    logic [31:0] m_dmem [DMEM];
    logic [31:0] m_pc, m_res;
    int          m_ptr;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Executes one instruction on the reference state
    task automatic model_exec(output logic st_en, output int st_idx, output logic [31:0] st_val);
        logic [31:0] ins, a, b, ii, is, ib, iu, ij, nxt, val, ea;
        logic [2:0]  f3;
        logic        wr, tk;
        int          rd;
        ins = m_imem[(m_pc / 4) % IMEM];
        f3  = ins[14:12];
        rd  = int'(ins[11:7]);
        a   = m_rf[ins[19:15]];
        b   = m_rf[ins[24:20]];
        ii  = 32'($signed(ins[31:20]));
        is  = 32'($signed({ins[31:25], ins[11:7]}));
        ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu  = {ins[31:12], 12'd0};
        ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        nxt = m_pc + 4;
        wr  = 1'b0;
        val = '0;
        st_en = 1'b0; st_idx = 0; st_val = '0;
        case (ins[6:0])
            7'h33: begin wr = 1'b1; val = alu_ref(f3, ins[30], a, b); end
            7'h13: begin wr = 1'b1; val = alu_ref(f3, (f3 == 3'd5) && ins[30], a, ii); end
            7'h03: if (f3 == 3'd2) begin
                ea = a + ii; wr = 1'b1; val = m_dmem[(ea / 4) % DMEM];
            end
            7'h23: if (f3 == 3'd2) begin
                ea = a + is; st_en = 1'b1; st_idx = int'((ea / 4) % DMEM); st_val = b;
            end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = m_pc + ib;
            end
            7'h6f: begin wr = 1'b1; val = m_pc + 4; nxt = m_pc + ij; end
            7'h67: if (f3 == 3'd0) begin wr = 1'b1; val = m_pc + 4; nxt = (a + ii) & ~32'd1; end
            7'h37: begin wr = 1'b1; val = iu; end
            7'h17: begin wr = 1'b1; val = m_pc + iu; end
            default: ;
        endcase
        if (st_en) m_dmem[st_idx] = st_val;
        if (wr && rd != 0) begin m_rf[rd] = val; m_res = val; end
        m_pc = nxt % (IMEM * 4);
    endtask

    // Drive one clock edge, advance the model and queue the predicted outcome
    task automatic cycle(input logic r, input logic e, input logic [31:0] w, input logic [95:0] nm,
                         input logic xr_en = 1'b0, input int xr_idx = 0, input logic [31:0] xr_val = '0);
        exp_t ent;
        rst = r; enable = e; instruction = w;
        ent.st_en = 1'b0; ent.st_idx = 0; ent.st_val = '0;
        if (r) begin
            m_pc = 0; m_ptr = 0; m_res = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
        end else if (e) begin
            m_imem[m_ptr] = w;
            m_ptr = (m_ptr + 1) % IMEM;
        end else begin
            model_exec(ent.st_en, ent.st_idx, ent.st_val);
        end
        ent.name = nm; ent.edge_no = edge_cnt + 1;
        ent.pc = m_pc; ent.res = m_res; ent.ptr = 8'(m_ptr);
        for (int i = 0; i < 32; i++) ent.rf[i*32 +: 32] = m_rf[i];
        ent.xr_en = xr_en; ent.xr_idx = xr_idx; ent.xr_val = xr_val;
        sb.push_back(ent);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input logic [95:0] nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %0s/%0s: got %08h expected %08h", nm, what, act, exp);
        end
    endtask

    // Monitor: compares each queued prediction once its edge has happened
    always @(negedge clk) begin
        exp_t e;
        int bad;
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            e = sb.pop_front();
            chk(e.name, "pc", dut.pc_q, e.pc);
            chk(e.name, "res_out", res_out, e.res);
            chk(e.name, "load_ptr", {24'd0, dut.load_ptr_q}, {24'd0, e.ptr});
            bad = -1;
            for (int i = 0; i < 32; i++)
                if (bad < 0 && dut.rf_q[i] !== e.rf[i*32 +: 32]) bad = i;
            if (bad < 0) chk(e.name, "regfile", 32'd0, 32'd0 + 32'(bad + 1));
            else chk(e.name, $sformatf("x%0d", bad), dut.rf_q[bad], e.rf[bad*32 +: 32]);
            if (e.st_en) chk(e.name, $sformatf("dmem[%0d]", e.st_idx), dut.dmem_q[e.st_idx], e.st_val);
            if (e.xr_en) chk(e.name, $sformatf("x%0d const", e.xr_idx), dut.rf_q[e.xr_idx], e.xr_val);
        end
    end

    function automatic logic [4:0] rr();
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [2:0]  bf3 [6];
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0, 1: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                               rr(), rr(), f3, rr());
            2, 3: begin
                if (f3 == 3'd1) imm[11:5] = 7'h00;
                if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_i(imm, rr(), f3, rr(), 7'h13);
            end
            4: return {20'($urandom), rr(), ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
            5: return enc_b(13'(($urandom_range(0, 1) == 1 ? 1 : -1) * 4 * $urandom_range(1, 8)),
                            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), bf3[$urandom_range(0, 5)]);
            6: return enc_j(21'(($urandom_range(0, 1) == 1 ? 1 : -1) * 4 * $urandom_range(1, 8)), rr());
            7: return enc_i(imm, rr(), 3'd0, rr(), 7'h67);
            8: if ($urandom_range(0, 1) == 1)
                   return enc_i(12'(4 * $urandom_range(0, 63)), 5'd0, 3'd2, rr(), 7'h03);
               else
                   return enc_s(12'(4 * $urandom_range(0, 63)), rr(), 5'd0, 3'd2);
            default: case ($urandom_range(0, 3))
                0: return {25'($urandom), 7'h0f};
                1: return enc_i(imm, rr(), 3'd0, rr(), 7'h03);
                2: return enc_s(imm, rr(), rr(), 3'd0);
                default: return enc_b(13'd8, rr(), rr(), 3'd2);
            endcase
        endcase
    endfunction

    initial begin
        logic [31:0] prog [$];
        rst = 1'b1; enable = 1'b0; instruction = '0;
        @(posedge clk);
        #2;

        cycle(1'b1, 1'b0, '0, "reset");

        // ADDI/ADD after load then reset
        prog = '{addi(1, 0, 5), addi(2, 0, 7), enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3)};
        foreach (prog[i]) cycle(1'b0, 1'b1, prog[i], "load_add");
        cycle(1'b1, 1'b0, '0, "rst_add");
        cycle(1'b0, 1'b0, '0, "run_add");
        cycle(1'b0, 1'b0, '0, "run_add");
        cycle(1'b0, 1'b0, '0, "run_add", 1'b1, 3, 32'd12);

        // SW then LW of all-ones word
        prog = '{addi(1, 0, -1), enc_s(12'd8, 5'd1, 5'd0, 3'd2), enc_i(12'd8, 5'd0, 3'd2, 5'd4, 7'h03)};
        foreach (prog[i]) cycle(1'b0, 1'b1, prog[i], "load_mem");
        cycle(1'b1, 1'b0, '0, "rst_mem");
        cycle(1'b0, 1'b0, '0, "run_mem");
        cycle(1'b0, 1'b0, '0, "run_mem");
        cycle(1'b0, 1'b0, '0, "run_mem", 1'b1, 4, 32'hFFFF_FFFF);

        // BEQ skip and JAL link
        prog = '{enc_b(13'd8, 5'd0, 5'd0, 3'd0), addi(6, 0, 1), addi(7, 0, 3), addi(8, 0, 4),
                 enc_j(21'd8, 5'd5), addi(9, 0, 1), addi(10, 0, 2)};
        foreach (prog[i]) cycle(1'b0, 1'b1, prog[i], "load_br");
        cycle(1'b1, 1'b0, '0, "rst_br");
        cycle(1'b0, 1'b0, '0, "run_br", 1'b1, 6, 32'd0);
        cycle(1'b0, 1'b0, '0, "run_br");
        cycle(1'b0, 1'b0, '0, "run_br");
        cycle(1'b0, 1'b0, '0, "run_br", 1'b1, 5, 32'd20);
        cycle(1'b0, 1'b0, '0, "run_br", 1'b1, 9, 32'd0);

        // x0 write, SRAI sign fill, SLTU, mid-run load mode, rst beating enable
        prog = '{addi(1, 0, 3), addi(0, 0, 9), {20'h80000, 5'd1, 7'h37},
                 enc_i(12'h404, 5'd1, 3'd5, 5'd2, 7'h13), addi(3, 0, 1), addi(4, 0, -1),
                 enc_r(7'h00, 5'd4, 5'd3, 3'd3, 5'd5)};
        foreach (prog[i]) cycle(1'b0, 1'b1, prog[i], "load_edge");
        cycle(1'b1, 1'b0, '0, "rst_edge");
        cycle(1'b0, 1'b0, '0, "run_edge");
        cycle(1'b0, 1'b0, '0, "x0_write", 1'b1, 0, 32'd0);
        cycle(1'b0, 1'b0, '0, "run_edge");
        cycle(1'b0, 1'b0, '0, "srai", 1'b1, 2, 32'hF800_0000);
        cycle(1'b0, 1'b1, addi(6, 0, 77), "midload");
        cycle(1'b0, 1'b1, addi(7, 0, 88), "midload");
        cycle(1'b0, 1'b0, '0, "run_edge");
        cycle(1'b0, 1'b0, '0, "run_edge");
        cycle(1'b0, 1'b0, '0, "sltu", 1'b1, 5, 32'd1);
        cycle(1'b1, 1'b1, addi(6, 0, 55), "rst_en");
        cycle(1'b0, 1'b0, '0, "after_rst", 1'b1, 6, 32'd77);
        cycle(1'b0, 1'b0, '0, "after_rst", 1'b1, 7, 32'd88);

        // Random programs: dmem preset by leading stores, then random code
        for (int round = 0; round < 2; round++) begin
            cycle(1'b1, 1'b0, '0, "rnd_rst");
            for (int i = 0; i < IMEM; i++)
                cycle(1'b0, 1'b1, (i < 64) ? enc_s(12'(4 * i), 5'(i % 8), 5'd0, 3'd2) : gen_instr(),
                      "rnd_load");
            cycle(1'b1, 1'b0, '0, "rnd_rst");
            for (int c = 0; c < 600; c++) begin
                int p;
                p = (c < 70) ? 99 : $urandom_range(0, 99);
                if (p < 3) begin
                    cycle(1'b0, 1'b1, gen_instr(), "rnd_midld");
                    cycle(1'b0, 1'b1, gen_instr(), "rnd_midld");
                end else if (p == 3) begin
                    cycle(1'b1, 1'b0, '0, "rnd_rst");
                end else if (p == 4) begin
                    cycle(1'b1, 1'b1, gen_instr(), "rnd_rst_en");
                end else begin
                    cycle(1'b0, 1'b0, '0, "rnd_exec");
                end
            end
        end

        enable = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
